// File: rtl/display_mux7seg.sv
// rtl/display_mux7seg.sv - time-multiplexed common-anode seven-segment scan driver
module display_mux7seg #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     blink_en,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic [4*N_DIGITS-1:0] shadow;
    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_phase;

    logic                  advance;
    logic                  wrap;

    logic [3:0]            cur_digit;
    logic                  cur_blink;
    logic                  cur_lz;
    logic                  higher_zero;
    logic [N_DIGITS-1:0]   suppress_lz;
    logic [N_DIGITS-1:0]   an_next;
    logic                  suppress;

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes go dark
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_OFF;
        endcase
    endfunction

    assign advance = (div_cnt == DIV_LAST);
    assign wrap    = advance && (idx == IDX_LAST);

    // Shadow register: the display only ever reads this copy of value
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (load)
            shadow <= value;
    end

    // Refresh divider sets the dwell time of each digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (advance)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Scan index steps once per dwell period and flags each frame wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (wrap)
                idx <= '0;
            else if (advance)
                idx <= idx + 1'b1;
        end
    end

    // Blink phase flips every BLINK_DIV frames, always at a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Select the current digit and work out whether it must be suppressed
    always_comb begin
        cur_digit   = 4'h0;
        cur_blink   = 1'b0;
        cur_lz      = 1'b0;
        higher_zero = 1'b1;
        suppress_lz = '0;
        an_next     = '1;
        // Walk from the most significant digit down; digit 0 always shows
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            higher_zero    = higher_zero && (shadow[4*i +: 4] == 4'h0);
            suppress_lz[i] = (i != 0) && higher_zero;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit  = shadow[4*i +: 4];
                cur_blink  = blink_en[i];
                cur_lz     = suppress_lz[i];
                an_next[i] = 1'b0;
            end
        end
        suppress = (blank_lz && cur_lz) || (cur_blink && blink_phase);
    end

    // Registered pin drivers, one cycle behind the scan index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else if (suppress) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else begin
            seg <= decode(cur_digit);
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_display_mux7seg.sv
// tb/tb_display_mux7seg.sv - directed self-checking bench for display_mux7seg
module tb_display_mux7seg;

    logic        clk;
    logic        rst_a, load_a, blank_a;
    logic [15:0] value_a;
    logic [3:0]  blink_a;
    logic [6:0]  seg_a;
    logic [3:0]  an_a;
    logic        ft_a;

    logic        rst_b, load_b, blank_b;
    logic [3:0]  value_b;
    logic [0:0]  blink_b;
    logic [6:0]  seg_b;
    logic [0:0]  an_b;
    logic        ft_b;

    int checks = 0;
    int passed = 0;

    display_mux7seg #(.N_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2)) dut_a (
        .clk(clk), .reset(rst_a), .load(load_a), .value(value_a),
        .blank_lz(blank_a), .blink_en(blink_a),
        .seg(seg_a), .an(an_a), .frame_tick(ft_a)
    );

    display_mux7seg #(.N_DIGITS(1), .REFRESH_DIV(3), .BLINK_DIV(1)) dut_b (
        .clk(clk), .reset(rst_b), .load(load_b), .value(value_b),
        .blank_lz(blank_b), .blink_en(blink_b),
        .seg(seg_b), .an(an_b), .frame_tick(ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset, release with a load pending; returns at the sample point after edge 1
    task automatic restart_a(input logic [15:0] v);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a   = 1'b0;
        load_a  = 1'b1;
        value_a = v;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        checks++; if (seg_a !== 7'b1111111) $display("FAIL reset_seg got=%b exp=1111111", seg_a); else passed++;
        checks++; if (an_a !== 4'b1111) $display("FAIL reset_an got=%b exp=1111", an_a); else passed++;
        checks++; if (ft_a !== 1'b0) $display("FAIL reset_ft got=%b exp=0", ft_a); else passed++;
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        checks++; if (seg_a !== 7'b1111111) $display("FAIL midreset_seg got=%b exp=1111111", seg_a); else passed++;
        checks++; if (an_a !== 4'b1111) $display("FAIL midreset_an got=%b exp=1111", an_a); else passed++;
        checks++; if (ft_a !== 1'b0) $display("FAIL midreset_ft got=%b exp=0", ft_a); else passed++;
        @(negedge clk);
        rst_a = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            ea = ~(4'b0001 << (((k - 1) / 4) % 4));
            checks++; if (an_a !== ea) $display("FAIL scan_an k=%0d got=%b exp=%b", k, an_a, ea); else passed++;
            checks++; if (ft_a !== (k % 16 == 0)) $display("FAIL scan_ft k=%0d got=%b exp=%b", k, ft_a, (k % 16 == 0)); else passed++;
            if (k % 4 == 2) begin
                checks++; if (seg_a !== 7'b1000000) $display("FAIL scan_seg k=%0d got=%b exp=1000000", k, seg_a); else passed++;
            end
        end
    endtask

    task automatic test_load_scan();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        int d;
        es = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        restart_a(16'h1234);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            d = (k - 1) / 4;
            if ((k - 1) % 4 != 0) begin
                checks++; if (an_a !== ea[d]) $display("FAIL load_scan_an k=%0d got=%b exp=%b", k, an_a, ea[d]); else passed++;
                checks++; if (seg_a !== es[d]) $display("FAIL load_scan_seg k=%0d got=%b exp=%b", k, seg_a, es[d]); else passed++;
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        int d;
        blank_a = 1'b1;
        es = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
        ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        restart_a(16'h0050);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            d = (k - 1) / 4;
            if ((k - 1) % 4 != 0) begin
                checks++; if (an_a !== ea[d]) $display("FAIL lz50_an k=%0d got=%b exp=%b", k, an_a, ea[d]); else passed++;
                checks++; if (seg_a !== es[d]) $display("FAIL lz50_seg k=%0d got=%b exp=%b", k, seg_a, es[d]); else passed++;
            end
        end
        es = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        restart_a(16'h0000);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            d = (k - 1) / 4;
            if ((k - 1) % 4 != 0) begin
                checks++; if (an_a !== ea[d]) $display("FAIL lz0_an k=%0d got=%b exp=%b", k, an_a, ea[d]); else passed++;
                checks++; if (seg_a !== es[d]) $display("FAIL lz0_seg k=%0d got=%b exp=%b", k, seg_a, es[d]); else passed++;
            end
        end
        blank_a = 1'b0;
    endtask

    task automatic test_blink();
        logic [6:0] es [4];
        logic [3:0] ea [4];
        logic [6:0] xs;
        logic [3:0] xa;
        int d, f;
        es = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        blink_a = 4'b0001;
        restart_a(16'h1234);
        for (int k = 2; k <= 128; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            f = (k - 1) / 16;
            if ((k - 1) % 4 == 2) begin
                if (d == 0 && (f % 4) >= 2) begin
                    xs = 7'b1111111;
                    xa = 4'b1111;
                end else begin
                    xs = es[d];
                    xa = ea[d];
                end
                checks++; if (an_a !== xa) $display("FAIL blink_an frame=%0d digit=%0d got=%b exp=%b", f, d, an_a, xa); else passed++;
                checks++; if (seg_a !== xs) $display("FAIL blink_seg frame=%0d digit=%0d got=%b exp=%b", f, d, seg_a, xs); else passed++;
            end
        end
        blink_a = 4'b0000;
    endtask

    task automatic test_invalid_and_load_timing();
        restart_a(16'h00A9);
        @(negedge clk);
        checks++; if (seg_a !== 7'b0010000) $display("FAIL inv_d0_seg got=%b exp=0010000", seg_a); else passed++;
        checks++; if (an_a !== 4'b1110) $display("FAIL inv_d0_an got=%b exp=1110", an_a); else passed++;
        @(negedge clk);
        load_a  = 1'b1;
        value_a = 16'h0001;
        @(negedge clk);
        load_a = 1'b0;
        checks++; if (seg_a !== 7'b0010000) $display("FAIL advload_e4_seg got=%b exp=0010000", seg_a); else passed++;
        checks++; if (an_a !== 4'b1110) $display("FAIL advload_e4_an got=%b exp=1110", an_a); else passed++;
        @(negedge clk);
        checks++; if (seg_a !== 7'b1000000) $display("FAIL advload_e5_seg got=%b exp=1000000", seg_a); else passed++;
        checks++; if (an_a !== 4'b1101) $display("FAIL advload_e5_an got=%b exp=1101", an_a); else passed++;
        for (int k = 0; k < 13; k++) @(negedge clk);
        checks++; if (seg_a !== 7'b1111001) $display("FAIL advload_d0_seg got=%b exp=1111001", seg_a); else passed++;
        checks++; if (an_a !== 4'b1110) $display("FAIL advload_d0_an got=%b exp=1110", an_a); else passed++;
        load_a  = 1'b1;
        value_a = 16'h0003;
        @(negedge clk);
        value_a = 16'h0008;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 0; k < 14; k++) @(negedge clk);
        checks++; if (seg_a !== 7'b0000000) $display("FAIL b2b_seg got=%b exp=0000000", seg_a); else passed++;
        checks++; if (an_a !== 4'b1110) $display("FAIL b2b_an got=%b exp=1110", an_a); else passed++;
    endtask

    task automatic test_single_digit();
        logic [6:0] xs;
        checks++; if (seg_b !== 7'b1111111) $display("FAIL n1_reset_seg got=%b exp=1111111", seg_b); else passed++;
        checks++; if (an_b !== 1'b1) $display("FAIL n1_reset_an got=%b exp=1", an_b); else passed++;
        checks++; if (ft_b !== 1'b0) $display("FAIL n1_reset_ft got=%b exp=0", ft_b); else passed++;
        @(negedge clk);
        rst_b   = 1'b0;
        load_b  = 1'b1;
        value_b = 4'h7;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            load_b = 1'b0;
            xs = (k == 1) ? 7'b1000000 : 7'b1111000;
            checks++; if (an_b !== 1'b0) $display("FAIL n1_an k=%0d got=%b exp=0", k, an_b); else passed++;
            checks++; if (ft_b !== (k % 3 == 0)) $display("FAIL n1_ft k=%0d got=%b exp=%b", k, ft_b, (k % 3 == 0)); else passed++;
            checks++; if (seg_b !== xs) $display("FAIL n1_seg k=%0d got=%b exp=%b", k, seg_b, xs); else passed++;
        end
    endtask

    initial begin
        rst_a = 1'b1; load_a = 1'b0; blank_a = 1'b0; value_a = '0; blink_a = '0;
        rst_b = 1'b1; load_b = 1'b0; blank_b = 1'b0; value_b = '0; blink_b = '0;
        #12;
        test_reset();
        test_load_scan();
        test_lz();
        test_blink();
        test_invalid_and_load_timing();
        test_single_digit();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
